// File: rtl/metro_gate_ctrl.sv
// Metro turnstile gate controller.
// Reads a card balance, deducts one fare, unlocks the gate and counts
// completed passages. A free-running prescaler provides the coarse
// timer tick. Insufficient balance raises a timed denial indication.
// Every flow ends in WAIT_REMOVE, so a card left in place is never
// charged twice.
module metro_gate_ctrl #(
  parameter int BAL_W      = 8,
  parameter int FARE       = 3,
  parameter int DIV        = 50000,
  parameter int OPEN_TICKS = 5,
  parameter int DENY_TICKS = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk_h,
  input  logic             reset,
  input  logic             card_inserted,
  input  logic [BAL_W-1:0] balance,
  input  logic             passed,
  output logic             gate_open,
  output logic             wr_en,
  output logic [BAL_W-1:0] new_balance,
  output logic [CNT_W-1:0] pass_count,
  output logic [2:0]       status,
  output logic [6:0]       hex
);

  // Prescaler width is sized for 0..DIV-1; the timer holds the larger tick load.
  localparam int PS_W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int TMR_MAX = (OPEN_TICKS > DENY_TICKS) ? OPEN_TICKS : DENY_TICKS;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [PS_W-1:0]  PS_ZERO   = {PS_W{1'b0}};
  localparam logic [PS_W-1:0]  PS_ONE    = {{(PS_W-1){1'b0}}, 1'b1};
  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(DIV - 1);
  localparam logic [TMR_W-1:0] TMR_ZERO  = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE   = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_TICKS);
  localparam logic [TMR_W-1:0] DENY_LOAD = TMR_W'(DENY_TICKS);
  localparam logic [BAL_W-1:0] BAL_ZERO  = {BAL_W{1'b0}};
  localparam logic [BAL_W-1:0] FARE_V    = BAL_W'(FARE);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // The encoding doubles as the externally visible status code.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_CHECK       = 3'd1,
    ST_DEDUCT      = 3'd2,
    ST_OPEN        = 3'd3,
    ST_DENY        = 3'd4,
    ST_WAIT_REMOVE = 3'd5
  } state_t;

  // Active-low seven-segment pattern {g,f,e,d,c,b,a}; unused codes blank the display.
  function automatic logic [6:0] seg_decode(input logic [2:0] code);
    logic [6:0] seg;
    case (code)
      3'd0:    seg = 7'b1000000;
      3'd1:    seg = 7'b1111001;
      3'd2:    seg = 7'b0100100;
      3'd3:    seg = 7'b0110000;
      3'd4:    seg = 7'b0011001;
      3'd5:    seg = 7'b0010010;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [PS_W-1:0]  prescale_r;
  logic             tick_s;
  logic [TMR_W-1:0] timer_r;
  logic [TMR_W-1:0] timer_s;
  logic [BAL_W-1:0] bal_r;
  logic [BAL_W-1:0] bal_s;
  logic [BAL_W-1:0] new_balance_r;
  logic [BAL_W-1:0] new_balance_s;
  logic [CNT_W-1:0] pass_count_r;
  logic [CNT_W-1:0] pass_count_s;
  logic             gate_open_r;
  logic             gate_open_s;
  logic             wr_en_r;
  logic             wr_en_s;

  assign tick_s = (prescale_r == PS_LAST);

  // Free-running prescaler: counts 0..DIV-1 and wraps to 0.
  always_ff @(posedge clk_h) begin
    if (reset) begin
      prescale_r <= PS_ZERO;
    end else if (tick_s) begin
      prescale_r <= PS_ZERO;
    end else begin
      prescale_r <= prescale_r + PS_ONE;
    end
  end

  // Next-state logic: sequencing, timers, fare deduction and passage counting.
  always_comb begin
    state_s       = state_r;
    timer_s       = timer_r;
    bal_s         = bal_r;
    new_balance_s = new_balance_r;
    pass_count_s  = pass_count_r;
    case (state_r)
      ST_IDLE: begin
        if (card_inserted) begin
          bal_s   = balance;
          state_s = ST_CHECK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        // The result is computed here so that it is already valid in DEDUCT.
        if (bal_r >= FARE_V) begin
          new_balance_s = bal_r - FARE_V;
          state_s       = ST_DEDUCT;
        end else begin
          timer_s = DENY_LOAD;
          state_s = ST_DENY;
        end
      end
      ST_DEDUCT: begin
        timer_s = OPEN_LOAD;
        state_s = ST_OPEN;
      end
      ST_OPEN: begin
        // A passage beats a timeout that expires on the same cycle.
        if (passed) begin
          if (pass_count_r == CNT_MAX) begin
            pass_count_s = CNT_MAX;
          end else begin
            pass_count_s = pass_count_r + CNT_ONE;
          end
          timer_s = TMR_ZERO;
          state_s = ST_WAIT_REMOVE;
        end else if (tick_s) begin
          if (timer_r <= TMR_ONE) begin
            timer_s = TMR_ZERO;
            state_s = ST_WAIT_REMOVE;
          end else begin
            timer_s = timer_r - TMR_ONE;
          end
        end else begin
          state_s = ST_OPEN;
        end
      end
      ST_DENY: begin
        if (tick_s) begin
          if (timer_r <= TMR_ONE) begin
            timer_s = TMR_ZERO;
            state_s = ST_WAIT_REMOVE;
          end else begin
            timer_s = timer_r - TMR_ONE;
          end
        end else begin
          state_s = ST_DENY;
        end
      end
      ST_WAIT_REMOVE: begin
        if (!card_inserted) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_REMOVE;
        end
      end
      default: begin
        timer_s = TMR_ZERO;
        state_s = ST_IDLE;
      end
    endcase
    // The outputs are decoded from the next state so that the registered copies track the state register.
    gate_open_s = (state_s == ST_OPEN);
    wr_en_s     = (state_s == ST_DEDUCT);
  end

  // State, datapath and output registers; reset overrides every input.
  always_ff @(posedge clk_h) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      timer_r       <= TMR_ZERO;
      bal_r         <= BAL_ZERO;
      new_balance_r <= BAL_ZERO;
      pass_count_r  <= CNT_ZERO;
      gate_open_r   <= 1'b0;
      wr_en_r       <= 1'b0;
    end else begin
      state_r       <= state_s;
      timer_r       <= timer_s;
      bal_r         <= bal_s;
      new_balance_r <= new_balance_s;
      pass_count_r  <= pass_count_s;
      gate_open_r   <= gate_open_s;
      wr_en_r       <= wr_en_s;
    end
  end

  assign gate_open   = gate_open_r;
  assign wr_en       = wr_en_r;
  assign new_balance = new_balance_r;
  assign pass_count  = pass_count_r;
  assign status      = state_r;
  assign hex         = seg_decode(status);

endmodule

// File: tb/tb_metro_gate_ctrl.sv
// Scoreboard bench for metro_gate_ctrl.
// The driver predicts the following for each card transaction:
//   - the status codes the gate steps through,
//   - the written-back balance,
//   - how long the gate stays open or the denial is held.
// These come from edge arithmetic on the prescaler period.
// A monitor pops the predictions as the DUT presents them.
module tb_metro_gate_ctrl;

  localparam int BAL_W      = 8;
  localparam int FARE       = 3;
  localparam int DIV        = 4;
  localparam int OPEN_TICKS = 3;
  localparam int DENY_TICKS = 2;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk_h         = 1'b0;
  logic             reset         = 1'b1;
  logic             card_inserted = 1'b0;
  logic [BAL_W-1:0] balance       = '0;
  logic             passed        = 1'b0;
  logic             gate_open;
  logic             wr_en;
  logic [BAL_W-1:0] new_balance;
  logic [CNT_W-1:0] pass_count;
  logic [2:0]       status;
  logic [6:0]       hex;

  typedef struct {
    int st;
    int cnt;
  } st_exp_t;

  st_exp_t st_q[$];
  int      wr_q[$];
  int      open_q[$];
  int      deny_q[$];
  int      n_checks  = 0;
  int      n_fail    = 0;
  int      edge_n    = 0;
  int      model_cnt = 0;

  metro_gate_ctrl #(
    .BAL_W(BAL_W), .FARE(FARE), .DIV(DIV),
    .OPEN_TICKS(OPEN_TICKS), .DENY_TICKS(DENY_TICKS), .CNT_W(CNT_W)
  ) dut (
    .clk_h(clk_h), .reset(reset), .card_inserted(card_inserted),
    .balance(balance), .passed(passed), .gate_open(gate_open),
    .wr_en(wr_en), .new_balance(new_balance), .pass_count(pass_count),
    .status(status), .hex(hex)
  );

  always #5 clk_h = ~clk_h;

  // Edges since the last reset edge; the prescaler ticks on edges that are multiples of DIV.
  initial forever begin
    @(posedge clk_h);
    if (reset) edge_n = 0;
    else       edge_n = edge_n + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int hex_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      default: return 7'b1111111;
    endcase
  endfunction

  // The n-th edge strictly after 'start' on which the prescaler ticks.
  function automatic int nth_tick(input int start, input int n);
    return ((start / DIV) + 1) * DIV + (n - 1) * DIV;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk_h);
    #1;
  endtask

  task automatic push_st(input int s);
    st_exp_t e;
    e.st  = s;
    e.cnt = model_cnt;
    st_q.push_back(e);
  endtask

  // Monitor: compares every status change, write pulse and open/deny interval against the scoreboard.
  initial begin : monitor
    int      prev_st;
    int      open_len;
    int      deny_len;
    st_exp_t e;
    prev_st  = 0;
    open_len = 0;
    deny_len = 0;
    forever begin
      @(negedge clk_h);
      if (reset) begin
        prev_st  = 0;
        open_len = 0;
        deny_len = 0;
      end else begin
        if (int'(status) != prev_st) begin
          if (st_q.size() == 0) begin
            chk("status_unexpected_change", int'(status), prev_st);
          end else begin
            e = st_q.pop_front();
            chk("status", int'(status), e.st);
            chk("pass_count", int'(pass_count), e.cnt);
            chk("hex", int'(hex), hex_of(e.st));
          end
          prev_st = int'(status);
        end
        if (wr_en) begin
          if (wr_q.size() == 0) chk("wr_en_unexpected", 1, 0);
          else chk("new_balance", int'(new_balance), wr_q.pop_front());
        end
        if (gate_open) begin
          open_len++;
        end else if (open_len > 0) begin
          if (open_q.size() == 0) chk("gate_open_unexpected", open_len, 0);
          else chk("gate_open_cycles", open_len, open_q.pop_front());
          open_len = 0;
        end
        if (status == 3'd4) begin
          deny_len++;
        end else if (deny_len > 0) begin
          if (deny_q.size() == 0) chk("deny_unexpected", deny_len, 0);
          else chk("deny_cycles", deny_len, deny_q.pop_front());
          deny_len = 0;
        end
      end
    end
  end

  // One card transaction. The card is seen at edge m0; 'passed' pulses at edge m0+pass_off
  // (none when negative). The card is pulled before edge m0+hold. The task then idles 'gap' edges.
  task automatic run_txn(input int bal, input int pass_off, input int hold, input int gap);
    int m0, m_p, m_open, m_to, m_exit, m_rm, m_idle, m_end;
    m0   = edge_n + 1;
    m_p  = (pass_off < 0) ? -1 : m0 + pass_off;
    m_rm = m0 + hold;
    push_st(1);
    if (bal >= FARE) begin
      wr_q.push_back(bal - FARE);
      push_st(2);
      push_st(3);
      m_open = m0 + 2;
      m_to   = nth_tick(m_open, OPEN_TICKS);
      if (m_p > m_open && m_p <= m_to) begin
        m_exit    = m_p;
        model_cnt = (model_cnt >= CNT_MAX) ? CNT_MAX : model_cnt + 1;
      end else begin
        m_exit = m_to;
      end
      open_q.push_back(m_exit - m_open);
    end else begin
      push_st(4);
      m_exit = nth_tick(m0 + 1, DENY_TICKS);
      deny_q.push_back(m_exit - (m0 + 1));
    end
    push_st(5);
    m_idle = (m_rm <= m_exit) ? m_exit + 1 : m_rm;
    push_st(0);
    m_end   = m_idle + gap;
    balance = BAL_W'(bal);
    while (edge_n < m_end) begin
      card_inserted = (edge_n + 1 < m_rm);
      passed        = (edge_n + 1 == m_p);
      step();
    end
    card_inserted = 1'b0;
    passed        = 1'b0;
  endtask

  initial begin : driver
    int m0;
    reset = 1'b1;
    repeat (3) step();
    chk("reset_gate_open", int'(gate_open), 0);
    chk("reset_wr_en", int'(wr_en), 0);
    chk("reset_new_balance", int'(new_balance), 0);
    chk("reset_pass_count", int'(pass_count), 0);
    chk("reset_status", int'(status), 0);
    chk("reset_hex", int'(hex), 7'b1000000);
    reset = 1'b0;
    step();

    // Paid passage, denial, timeout without passage, long hold then reinsertion.
    run_txn(10, 5, 8, 2);
    run_txn(2, -1, 3, 2);
    run_txn(3, -1, 2, 1);
    run_txn(20, 4, 40, 2);
    run_txn(20, 6, 1, 3);

    // A passage pulse with no card present is ignored.
    passed = 1'b1;
    step();
    passed = 1'b0;
    step();
    chk("idle_pass_ignored", int'(pass_count), model_cnt);
    chk("idle_status", int'(status), 0);

    // Drive the counter into saturation.
    repeat (16) run_txn(200, 4, 2, 1);
    chk("pass_count_saturated", int'(pass_count), CNT_MAX);

    // Randomised transactions: balances around the fare, passage pulses anywhere in the flow.
    repeat (40) begin
      int bal, po, hold, gap;
      bal  = int'($urandom_range(0, 40));
      po   = ($urandom_range(0, 9) < 2) ? -1 : int'($urandom_range(0, 18));
      hold = int'($urandom_range(1, 40));
      gap  = int'($urandom_range(1, 4));
      run_txn(bal, po, hold, gap);
    end

    // Reset while the gate is open: the gate closes and a same-cycle passage is dropped.
    m0 = edge_n + 1;
    push_st(1);
    push_st(2);
    push_st(3);
    wr_q.push_back(50 - FARE);
    balance       = 8'd50;
    card_inserted = 1'b1;
    while (edge_n < m0 + 3) step();
    chk("open_before_reset", int'(gate_open), 1);
    reset  = 1'b1;
    passed = 1'b1;
    step();
    chk("reset_open_gate", int'(gate_open), 0);
    chk("reset_open_status", int'(status), 0);
    chk("reset_open_hex", int'(hex), 7'b1000000);
    chk("reset_open_count", int'(pass_count), 0);
    chk("reset_open_wr_en", int'(wr_en), 0);
    model_cnt     = 0;
    reset         = 1'b0;
    passed        = 1'b0;
    card_inserted = 1'b0;
    step();
    run_txn(9, 5, 3, 2);
    chk("count_after_reset", int'(pass_count), 1);

    step();
    chk("status_queue_drained", st_q.size(), 0);
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("open_queue_drained", open_q.size(), 0);
    chk("deny_queue_drained", deny_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/metro_gate_ctrl.md
METRO_GATE_CTRL -- requirements
Module: metro_gate_ctrl

Interface
REQ-001 Parameter BAL_W, default 8: card balance width in bits.
REQ-002 Parameter FARE, default 3: fare deducted per passage; SHALL satisfy 1 <= FARE < 2^BAL_W.
REQ-003 Parameter DIV, default 50000: clk_h cycles per timer tick; SHALL be >= 2.
REQ-004 Parameter OPEN_TICKS, default 5: ticks the gate stays open awaiting passage; SHALL be >= 1.
REQ-005 Parameter DENY_TICKS, default 3: ticks the denial indication is held; SHALL be >= 1.
REQ-006 Parameter CNT_W, default 16: passage counter width.
REQ-007 clk_h  input  1  single clock; all state updates on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 card_inserted  input  1  level; high while a card is present.
REQ-010 balance  input  BAL_W  card balance; valid while card_inserted is high.
REQ-011 passed  input  1  one-cycle pulse from the passage sensor.
REQ-012 gate_open  output  1  high while the turnstile is unlocked.
REQ-013 wr_en  output  1  one-cycle pulse requesting a card write-back.
REQ-014 new_balance  output  BAL_W  balance to write; valid when wr_en is high, held otherwise.
REQ-015 pass_count  output  CNT_W  count of completed paid passages.
REQ-016 status  output  3  current state code.
REQ-017 hex  output  7  active-low seven-segment pattern {g,f,e,d,c,b,a} showing the status digit.

Function
REQ-018 Prescaler counts 0..DIV-1 continuously and wraps to 0; tick SHALL be high for exactly the one cycle the count equals DIV-1.
REQ-019 States and status codes: IDLE=0, CHECK=1, DEDUCT=2, OPEN=3, DENY=4, WAIT_REMOVE=5; codes 6 and 7 are unused.
REQ-020 IDLE: when card_inserted=1, latch balance into bal_q and go to CHECK on the next edge.
REQ-021 CHECK (1 cycle): bal_q >= FARE -> DEDUCT; otherwise -> DENY with the deny timer loaded to DENY_TICKS.
REQ-022 DEDUCT (1 cycle): wr_en=1 and new_balance=bal_q-FARE; go to OPEN with the open timer loaded to OPEN_TICKS.
REQ-023 The subtraction SHALL be unsigned at BAL_W bits; no underflow is possible given REQ-021.
REQ-024 OPEN: gate_open=1; the timer decrements on each tick.
REQ-025 OPEN, passed=1: pass_count increments, saturating at 2^CNT_W-1, and the state goes to WAIT_REMOVE.
REQ-026 OPEN, timer=1 on a tick with passed=0: timeout to WAIT_REMOVE with no count; the fare stays deducted.
REQ-027 OPEN, passed=1 and timeout in the same cycle: passed wins and the count increments.
REQ-028 DENY: decrements on each tick; on the tick where the timer=1, go to WAIT_REMOVE.
REQ-029 WAIT_REMOVE: card_inserted=0 -> IDLE; a card still present never triggers a second charge.
REQ-030 Card removal in CHECK, DEDUCT, OPEN or DENY SHALL NOT abort the sequence; it completes and then passes through WAIT_REMOVE.
REQ-031 passed outside OPEN SHALL be ignored.
REQ-032 gate_open is high only in OPEN; wr_en is high only in DEDUCT.
REQ-033 status = code of the current state; hex is combinational from status.
REQ-034 hex patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6/7=1111111.

Reset
REQ-035 With reset=1 at an edge: state=IDLE, prescaler=0, timers=0, bal_q=0, new_balance=0, pass_count=0, gate_open=0, wr_en=0, status=0, hex=1000000.
REQ-036 Reset takes priority over all inputs in every state, including mid-OPEN: the gate closes on that edge and a pending count is dropped.

Verification (DIV=4, FARE=3, OPEN_TICKS=3, DENY_TICKS=2, BAL_W=8, CNT_W=4)
REQ-037 balance=10, card inserted, passed pulsed in OPEN -> wr_en pulses once with new_balance=7, gate_open high, pass_count 0->1, status 0,1,2,3,5, then 0 after removal.
REQ-038 balance=2 -> status 1 then 4; no wr_en; gate_open stays 0; exactly 2 ticks (about 8 cycles) in DENY, then 5.
REQ-039 balance=3, no passed -> new_balance=0; gate open for 3 ticks, then WAIT_REMOVE with pass_count unchanged.
REQ-040 Card held across WAIT_REMOVE for 20 cycles -> no second wr_en; removal gives IDLE; reinsertion starts a new charge.
REQ-041 pass_count=15 plus one more passage -> stays 15; passed pulse in IDLE -> no change.
REQ-042 reset asserted in OPEN -> next edge gate_open=0, status=0, hex=1000000, pass_count=0.
